// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the two-pixels-per-clock receive path.
// Pixel and pair structs use PIX_DW bits per channel; the top-level DATA_W
// parameter defaults to PIX_DW and must stay equal to it.
package pixel_stream_pkg;

  localparam int PIX_DW = 8;

  // Luma weights; they sum to 256 so a flat grey input maps to itself.
  localparam int GRAY_CR = 77;
  localparam int GRAY_CG = 150;
  localparam int GRAY_CB = 29;

  typedef struct packed {
    logic [PIX_DW-1:0] r;
    logic [PIX_DW-1:0] g;
    logic [PIX_DW-1:0] b;
  } pixel_t;

  typedef struct packed {
    pixel_t p0;
    pixel_t p1;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P0    = 2'd1,
    P1    = 2'd2
  } ser_state_t;

  // Y = (77R + 150G + 29B) >> 8 with an 18-bit accumulator, truncating.
  function automatic pixel_t to_gray(input pixel_t px);
    logic [17:0]       acc;
    logic [PIX_DW-1:0] y;
    acc = 18'(GRAY_CR) * 18'(px.r)
        + 18'(GRAY_CG) * 18'(px.g)
        + 18'(GRAY_CB) * 18'(px.b);
    y = acc[8 +: PIX_DW];
    return {y, y, y};
  endfunction

endpackage

// File: rtl/pixel_stream_rx_fifo.sv
// pixel_pair_fifo: synchronous FIFO of pixel pairs with flush.
// The head entry is always presented on 'head' while not empty, so the
// consumer can pop and use the data in the same cycle. Storage is a plain
// array with a registered read; a write into the slot that becomes the head
// is forwarded through a bypass register.
module pixel_pair_fifo
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  pair_t push_data,
  input  logic  pop,
  output pair_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pair_t         mem [DEPTH];
  pair_t         ram_q_reg;
  pair_t         bypass_data_reg;
  logic          bypass_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_next;
  logic          pop_ok;
  logic          push_ok;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = bypass_reg ? bypass_data_reg : ram_q_reg;

  // Resolve the effective push/pop and next addresses; flush restarts at slot 0
  always_comb begin
    pop_ok       = pop & ~empty & ~flush;
    push_ok      = push & (flush | ~full | pop_ok);
    wr_addr      = flush ? '0 : wr_ptr_reg;
    rd_addr_next = flush ? '0 : (pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg);
    if (flush) begin
      count_next = push_ok ? (AW+1)'(1) : '0;
    end else begin
      count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= push_ok ? wr_addr + 1'b1 : wr_addr;
      rd_ptr_reg <= rd_addr_next;
      count_reg  <= count_next;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_addr] <= push_data;
    end
  end

  // Registered read of the next head, plus forwarding of a same-slot write
  always_ff @(posedge clk) begin
    ram_q_reg       <= mem[rd_addr_next];
    bypass_reg      <= push_ok && (wr_addr == rd_addr_next);
    bypass_data_reg <= push_data;
  end

endmodule

// File: rtl/pixel_stream_rx.sv
// pixel_stream_rx: captures HSYNC-qualified pixel pairs, buffers them and
// replays them one pixel per clock on a valid/ready interface with column,
// row, end-of-line and end-of-frame tags. A VSYNC rising edge restarts the
// frame; OVERFLOW and FRAME_ERR are sticky until reset.
// Build option: define PIX_GRAY_EN to convert each pixel to luma at load.
module pixel_stream_rx
  import pixel_stream_pkg::*;
#(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 512,
  parameter int DATA_W     = PIX_DW
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      VSYNC,
  input  logic                      HSYNC,
  input  logic [DATA_W-1:0]         DATA_R0,
  input  logic [DATA_W-1:0]         DATA_G0,
  input  logic [DATA_W-1:0]         DATA_B0,
  input  logic [DATA_W-1:0]         DATA_R1,
  input  logic [DATA_W-1:0]         DATA_G1,
  input  logic [DATA_W-1:0]         DATA_B1,
  output logic                      PIX_VALID,
  input  logic                      PIX_READY,
  output logic [DATA_W-1:0]         PIX_R,
  output logic [DATA_W-1:0]         PIX_G,
  output logic [DATA_W-1:0]         PIX_B,
  output logic [$clog2(WIDTH)-1:0]  PIX_COL,
  output logic [$clog2(HEIGHT)-1:0] PIX_ROW,
  output logic                      PIX_EOL,
  output logic                      PIX_EOF,
  output logic                      OVERFLOW,
  output logic                      FRAME_ERR
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  ser_state_t    state_reg;
  pixel_t        pix_reg;
  pixel_t        p1_hold_reg;
  logic          valid_reg;
  logic [CW-1:0] col_reg;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_reg;
  logic [RW-1:0] row_next;
  logic          eol_reg;
  logic          eof_reg;
  logic          overflow_reg;
  logic          frame_err_reg;
  logic          vsync_d_reg;

  pair_t         pair_in;
  pair_t         fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          vsync_rise;
  logic          accept;
  logic          drop;

  // Applied to every pixel as it is loaded into the output register
  function automatic pixel_t load_pix(input pixel_t px);
`ifdef PIX_GRAY_EN
    return to_gray(px);
`else
    return px;
`endif
  endfunction

  assign pair_in    = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
  assign vsync_rise = VSYNC & ~vsync_d_reg;
  assign accept     = valid_reg & PIX_READY;
  // A new pair is needed when idle, or when the odd pixel is being taken
  assign fifo_pop   = ~vsync_rise & ~fifo_empty &
                      ((state_reg == EMPTY) | ((state_reg == P1) & PIX_READY));
  assign drop       = HSYNC & fifo_full & ~fifo_pop & ~vsync_rise;

  assign PIX_VALID = valid_reg;
  assign PIX_R     = pix_reg.r;
  assign PIX_G     = pix_reg.g;
  assign PIX_B     = pix_reg.b;
  assign PIX_COL   = col_reg;
  assign PIX_ROW   = row_reg;
  assign PIX_EOL   = eol_reg;
  assign PIX_EOF   = eof_reg;
  assign OVERFLOW  = overflow_reg;
  assign FRAME_ERR = frame_err_reg;

  pixel_pair_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .flush    (vsync_rise),
    .push     (HSYNC),
    .push_data(pair_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Delay VSYNC one clock for rising-edge detection
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      vsync_d_reg <= 1'b0;
    end else begin
      vsync_d_reg <= VSYNC;
    end
  end

  // Serialiser: split each pair into two pixels, holding while not ready
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg   <= EMPTY;
      valid_reg   <= 1'b0;
      pix_reg     <= '0;
      p1_hold_reg <= '0;
    end else if (vsync_rise) begin
      state_reg <= EMPTY;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (!fifo_empty) begin
            pix_reg     <= load_pix(fifo_head.p0);
            p1_hold_reg <= fifo_head.p1;
            valid_reg   <= 1'b1;
            state_reg   <= P0;
          end
        end
        P0: begin
          if (PIX_READY) begin
            pix_reg   <= load_pix(p1_hold_reg);
            state_reg <= P1;
          end
        end
        P1: begin
          if (PIX_READY) begin
            if (!fifo_empty) begin
              pix_reg     <= load_pix(fifo_head.p0);
              p1_hold_reg <= fifo_head.p1;
              state_reg   <= P0;
            end else begin
              valid_reg <= 1'b0;
              state_reg <= EMPTY;
            end
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= EMPTY;
        end
      endcase
    end
  end

  // Next column/row position after an accepted pixel
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // Position counters and the line/frame end tags derived from them
  always_ff @(posedge HCLK) begin
    if (!HRESETn || vsync_rise) begin
      col_reg <= '0;
      row_reg <= '0;
      eol_reg <= 1'b0;
      eof_reg <= 1'b0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      eol_reg <= (col_next == COL_LAST);
      eof_reg <= (col_next == COL_LAST) && (row_next == ROW_LAST);
    end
  end

  // Sticky error flags
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (vsync_rise && ((col_reg != '0) || (row_reg != '0) ||
                         !fifo_empty || (state_reg != EMPTY))) begin
        frame_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_rx.sv
// Testbench for pixel_stream_rx: a queue-based model of the receive path is
// compared against the DUT every cycle, with directed scenarios pinned by
// hand-computed values followed by a randomized phase.
module tb_pixel_stream_rx;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int D  = 2;
  localparam int DW = 8;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          VSYNC = 1'b0;
  logic          HSYNC = 1'b0;
  logic          PIX_READY = 1'b0;
  logic [DW-1:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [DW-1:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic          PIX_VALID;
  logic [DW-1:0] PIX_R, PIX_G, PIX_B;
  logic [CW-1:0] PIX_COL;
  logic [RW-1:0] PIX_ROW;
  logic          PIX_EOL, PIX_EOF, OVERFLOW, FRAME_ERR;

  pixel_stream_rx #(
    .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .DATA_W(DW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
    .PIX_COL(PIX_COL), .PIX_ROW(PIX_ROW),
    .PIX_EOL(PIX_EOL), .PIX_EOF(PIX_EOF),
    .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [47:0] mq[$];   // buffered pairs {p0,p1}, each pixel {r,g,b}
  logic [23:0] sq[$];   // pixels of the pair being shown; front is on the outputs
  int          m_col = 0;
  int          m_row = 0;
  bit          m_ovf = 1'b0;
  bit          m_ferr = 1'b0;
  bit          m_vs_prev = 1'b0;

  function automatic logic [23:0] shade(input logic [23:0] px);
`ifdef PIX_GRAY_EN
    int y;
    y = (77 * int'(px[23:16]) + 150 * int'(px[15:8]) + 29 * int'(px[7:0])) / 256;
    return {y[7:0], y[7:0], y[7:0]};
`else
    return px;
`endif
  endfunction

  always @(posedge HCLK) begin
    logic [47:0] pr;
    logic [47:0] hd;
    bit          rise;
    pr = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
    if (!HRESETn) begin
      mq.delete();
      sq.delete();
      m_col = 0;
      m_row = 0;
      m_ovf = 1'b0;
      m_ferr = 1'b0;
      m_vs_prev = 1'b0;
    end else begin
      rise = VSYNC && !m_vs_prev;
      m_vs_prev = VSYNC;
      if (rise) begin
        if (m_col != 0 || m_row != 0 || mq.size() != 0 || sq.size() != 0) m_ferr = 1'b1;
        mq.delete();
        sq.delete();
        m_col = 0;
        m_row = 0;
        if (HSYNC) mq.push_back(pr);
      end else begin
        if (sq.size() > 0 && PIX_READY) begin
          void'(sq.pop_front());
          if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
          end else begin
            m_col++;
          end
        end
        if (sq.size() == 0 && mq.size() > 0) begin
          hd = mq.pop_front();
          sq.push_back(shade(hd[47:24]));
          sq.push_back(shade(hd[23:0]));
        end
        if (HSYNC) begin
          if (mq.size() < D) mq.push_back(pr);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge HCLK) begin
    logic [63:0] a;
    logic [63:0] e;
    bit          v;
    if (chk_en) begin
      v = (sq.size() > 0);
      a = 64'({PIX_VALID, (v ? {PIX_R, PIX_G, PIX_B} : 24'h0), 8'(PIX_COL), 8'(PIX_ROW),
               PIX_EOL, PIX_EOF, OVERFLOW, FRAME_ERR});
      e = 64'({v, (v ? sq[0] : 24'h0), 8'(m_col), 8'(m_row),
               1'(m_col == W - 1), 1'(m_col == W - 1 && m_row == H - 1), m_ovf, m_ferr});
      chk("cycle", a, e);
    end
  end

  // ---------------- accepted-pixel log ----------------
  typedef struct {
    logic [7:0] r, g, b;
    int         col, row;
    bit         eol, eof;
  } ent_t;
  ent_t log_q[$];

  always @(negedge HCLK) begin
    ent_t en;
    if (HRESETn && PIX_VALID && PIX_READY) begin
      en.r = PIX_R; en.g = PIX_G; en.b = PIX_B;
      en.col = int'(PIX_COL); en.row = int'(PIX_ROW);
      en.eol = PIX_EOL; en.eof = PIX_EOF;
      log_q.push_back(en);
      $display("pix r=%0d g=%0d b=%0d col=%0d row=%0d eol=%0b eof=%0b",
               PIX_R, PIX_G, PIX_B, PIX_COL, PIX_ROW, PIX_EOL, PIX_EOF);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit rstn, input bit vs, input bit hs, input bit rdy,
                      input logic [47:0] pr);
    HRESETn = rstn;
    VSYNC = vs;
    HSYNC = hs;
    PIX_READY = rdy;
    {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = pr;
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [47:0] mkpair(input int i);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(2 * i);
    b = 8'(2 * i + 1);
    return {a, a, a, b, b, b};
  endfunction

  // Accepted pixels must be first..first+n-1 from column 0, row 0
  task automatic check_seq(input string tag, input int n, input int first);
    logic [7:0] v;
    chk({tag, "_count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      v = 8'(first + i);
      chk({tag, "_pix"},
          64'({log_q[i].r, log_q[i].g, log_q[i].b, 8'(log_q[i].col), 8'(log_q[i].row),
               log_q[i].eol, log_q[i].eof}),
          64'({v, v, v, 8'(i % W), 8'((i / W) % H),
               1'(i % W == W - 1), 1'(i % W == W - 1 && (i / W) % H == H - 1)}));
    end
  endtask

  initial begin
    logic [63:0] rnd;
    bit          vs_r;

    // Reset
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk_en = 1'b1;
    chk("reset_outputs",
        64'({PIX_VALID, PIX_R, PIX_G, PIX_B, 8'(PIX_COL), 8'(PIX_ROW), PIX_EOL, PIX_EOF,
             OVERFLOW, FRAME_ERR}), 64'h0);

    // Frame of 8 pairs, READY high
    step(1, 1, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    chk("t1_no_ferr", 64'(FRAME_ERR), 64'h0);
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 1, mkpair(i));
      if (i == 0) chk("t1_lat_k", 64'(PIX_VALID), 64'h0);
      step(1, 0, 0, 1, '0);
      if (i == 0) chk("t1_lat_k1", 64'({PIX_VALID, PIX_R}), 64'({1'b1, 8'd0}));
    end
    repeat (6) step(1, 0, 0, 1, '0);
    check_seq("t1", 16, 0);

    // Same frame with READY toggling
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 1, mkpair(i));
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 1, '0);
      step(1, 0, 0, 0, '0);
    end
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1'(i % 2 == 0), '0);
    check_seq("t2", 16, 0);

    // Overflow: READY low, four back-to-back pairs. The first pair moves into
    // the serialiser, the next two fill the FIFO, the fourth is dropped.
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, mkpair(i));
      if (i == 2) chk("t3_no_ovf_yet", 64'(OVERFLOW), 64'h0);
      if (i == 3) chk("t3_ovf", 64'(OVERFLOW), 64'h1);
    end
    repeat (10) step(1, 0, 0, 1, '0);
    check_seq("t3", 6, 0);

    // VSYNC mid-frame
    step(0, 0, 0, 1, '0);
    chk("t4_reset", 64'({PIX_VALID, OVERFLOW, FRAME_ERR}), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, mkpair(i));
      step(1, 0, 0, 1, '0);
    end
    step(1, 1, 0, 1, '0);
    chk("t4_ferr", 64'({FRAME_ERR, PIX_VALID, 8'(PIX_COL), 8'(PIX_ROW)}), 64'({1'b1, 1'b0, 16'h0}));
    step(1, 0, 0, 1, '0);
    chk("t4_flushed", 64'(PIX_VALID), 64'h0);
    log_q.delete();
    step(1, 0, 1, 1, mkpair(32));
    repeat (4) step(1, 0, 0, 1, '0);
    check_seq("t4", 2, 64);

    // Reset while showing the odd pixel
    step(0, 0, 0, 1, '0);
    step(1, 0, 1, 1, mkpair(0));
    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    chk("t5_in_p1", 64'({PIX_VALID, 8'(PIX_COL), PIX_R}), 64'({1'b1, 8'd1, 8'd1}));
    step(0, 0, 0, 1, '0);
    chk("t5_reset_outputs",
        64'({PIX_VALID, PIX_R, PIX_G, PIX_B, 8'(PIX_COL), 8'(PIX_ROW), PIX_EOL, PIX_EOF,
             OVERFLOW, FRAME_ERR}), 64'h0);
    step(1, 0, 0, 1, '0);
    chk("t5_fifo_empty", 64'(PIX_VALID), 64'h0);
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1, mkpair(i));
      step(1, 0, 0, 1, '0);
    end
    repeat (6) step(1, 0, 0, 1, '0);
    check_seq("t5", 8, 0);

    // Colour conversion of a known pixel
    log_q.delete();
    step(1, 0, 1, 1, {8'd200, 8'd100, 8'd50, 8'd200, 8'd100, 8'd50});
    repeat (4) step(1, 0, 0, 1, '0);
    chk("t6_count", 64'(log_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < log_q.size(); i++) begin
`ifdef PIX_GRAY_EN
      chk("t6_gray", 64'({log_q[i].r, log_q[i].g, log_q[i].b}), 64'({8'd124, 8'd124, 8'd124}));
`else
      chk("t6_rgb", 64'({log_q[i].r, log_q[i].g, log_q[i].b}), 64'({8'd200, 8'd100, 8'd50}));
`endif
    end

    // Randomized traffic, checked cycle by cycle against the model
    vs_r = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) < 3) vs_r = ~vs_r;
      rnd = {$urandom, $urandom};
      step(1'($urandom_range(0, 399) != 0), vs_r, 1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 99) < 70), rnd[47:0]);
    end
    log_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
